// File: rtl/cpu_pkg.sv
// Shared pipeline types: widths, ALU opcodes, forward-select encoding, ID/EX payloads.
package cpu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RAW     = 5;
  localparam int unsigned ALUOP_W = 5;

  localparam logic [ALUOP_W-1:0] ALUOP_NOP = 5'b00000;
  localparam logic [ALUOP_W-1:0] ALUOP_ADD = 5'b00001;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB = 5'b00010;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // Control half of the ID/EX register; all-zero is a bubble
  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } ex_ctrl_t;

  typedef struct packed {
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
  } ex_data_t;

  localparam ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID inputs, pipeline control, forward sources and EX outputs.
interface id_ex_stage_if;

  logic                          id_valid;
  logic [cpu_pkg::RAW-1:0]       id_rs1;
  logic [cpu_pkg::RAW-1:0]       id_rs2;
  logic                          id_uses_rs1;
  logic                          id_uses_rs2;
  logic [cpu_pkg::XLEN-1:0]      id_rs1_data;
  logic [cpu_pkg::XLEN-1:0]      id_rs2_data;
  logic [cpu_pkg::XLEN-1:0]      id_imm;
  logic [cpu_pkg::RAW-1:0]       id_rd;
  logic [cpu_pkg::ALUOP_W-1:0]   id_alu_op;
  logic                          id_alu_src;
  logic                          id_reg_write;
  logic                          id_mem_read;
  logic                          id_mem_write;
  logic                          id_mem_to_reg;
  logic                          flush;
  logic                          hold;
  logic                          exmem_reg_write;
  logic [cpu_pkg::RAW-1:0]       exmem_rd;
  logic [cpu_pkg::XLEN-1:0]      exmem_result;
  logic                          memwb_reg_write;
  logic [cpu_pkg::RAW-1:0]       memwb_rd;
  logic [cpu_pkg::XLEN-1:0]      memwb_result;
  logic [cpu_pkg::XLEN-1:0]      alu_a;
  logic [cpu_pkg::XLEN-1:0]      alu_b;
  logic [cpu_pkg::ALUOP_W-1:0]   alu_op;
  logic [cpu_pkg::XLEN-1:0]      store_data;
  logic [cpu_pkg::RAW-1:0]       ex_rd;
  logic                          ex_valid;
  logic                          ex_reg_write;
  logic                          ex_mem_read;
  logic                          ex_mem_write;
  logic                          ex_mem_to_reg;
  logic                          stall_id;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rs1_data, id_rs2_data,
           id_imm, id_rd, id_alu_op, id_alu_src, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, flush, hold, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  alu_a, alu_b, alu_op, store_data, ex_rd, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_mem_to_reg, stall_id
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rs1_data, id_rs2_data,
           id_imm, id_rd, id_alu_op, id_alu_src, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, flush, hold, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output alu_a, alu_b, alu_op, store_data, ex_rd, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_mem_to_reg, stall_id
  );

endinterface

// File: rtl/forward_unit.sv
// Operand bypass for one source register: EX/MEM beats MEM/WB, x0 never forwarded.
module forward_unit
  import cpu_pkg::*;
(
  input  logic [RAW-1:0]  rs_i,
  input  logic [XLEN-1:0] rf_data_i,
  input  logic            exmem_reg_write_i,
  input  logic [RAW-1:0]  exmem_rd_i,
  input  logic [XLEN-1:0] exmem_result_i,
  input  logic            memwb_reg_write_i,
  input  logic [RAW-1:0]  memwb_rd_i,
  input  logic [XLEN-1:0] memwb_result_i,
  output fwd_sel_e        sel_c_o,
  output logic [XLEN-1:0] data_c_o
);

  always_comb begin
    sel_c_o  = FWD_RF;
    data_c_o = rf_data_i;
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i)) begin
      sel_c_o  = FWD_EXMEM;
      data_c_o = exmem_result_i;
    end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i)) begin
      sel_c_o  = FWD_MEMWB;
      data_c_o = memwb_result_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/hold and operand forwarding.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);

  ex_ctrl_t        ctrl_q, ctrl_d;
  ex_data_t        data_q, data_d;
  ex_ctrl_t        id_ctrl_c;
  logic            load_use_c;
  fwd_sel_e        fwd1_sel_c, fwd2_sel_c;
  logic [XLEN-1:0] fwd1_data_c, fwd2_data_c;

  // An invalid ID slot is captured with all control cleared
  always_comb begin
    id_ctrl_c = CTRL_BUBBLE;
    if (bus.id_valid) begin
      id_ctrl_c.valid      = 1'b1;
      id_ctrl_c.reg_write  = bus.id_reg_write;
      id_ctrl_c.mem_read   = bus.id_mem_read;
      id_ctrl_c.mem_write  = bus.id_mem_write;
      id_ctrl_c.mem_to_reg = bus.id_mem_to_reg;
      id_ctrl_c.alu_src    = bus.id_alu_src;
      id_ctrl_c.alu_op     = bus.id_alu_op;
    end
  end

  assign load_use_c = ctrl_q.valid && ctrl_q.mem_read && (data_q.rd != '0) && bus.id_valid &&
                      ((bus.id_uses_rs1 && (bus.id_rs1 == data_q.rd)) ||
                       (bus.id_uses_rs2 && (bus.id_rs2 == data_q.rd)));

  // Priority: flush > hold > load-use bubble > capture
  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (bus.flush) begin
      ctrl_d = CTRL_BUBBLE;
    end else if (!bus.hold) begin
      if (load_use_c) begin
        ctrl_d = CTRL_BUBBLE;
      end else begin
        ctrl_d          = id_ctrl_c;
        data_d.rs1      = bus.id_rs1;
        data_d.rs2      = bus.id_rs2;
        data_d.rd       = bus.id_rd;
        data_d.rs1_data = bus.id_rs1_data;
        data_d.rs2_data = bus.id_rs2_data;
        data_d.imm      = bus.id_imm;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= CTRL_BUBBLE;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  forward_unit u_fwd_rs1 (
    .rs_i              (data_q.rs1),
    .rf_data_i         (data_q.rs1_data),
    .exmem_reg_write_i (bus.exmem_reg_write),
    .exmem_rd_i        (bus.exmem_rd),
    .exmem_result_i    (bus.exmem_result),
    .memwb_reg_write_i (bus.memwb_reg_write),
    .memwb_rd_i        (bus.memwb_rd),
    .memwb_result_i    (bus.memwb_result),
    .sel_c_o           (fwd1_sel_c),
    .data_c_o          (fwd1_data_c)
  );

  forward_unit u_fwd_rs2 (
    .rs_i              (data_q.rs2),
    .rf_data_i         (data_q.rs2_data),
    .exmem_reg_write_i (bus.exmem_reg_write),
    .exmem_rd_i        (bus.exmem_rd),
    .exmem_result_i    (bus.exmem_result),
    .memwb_reg_write_i (bus.memwb_reg_write),
    .memwb_rd_i        (bus.memwb_rd),
    .memwb_result_i    (bus.memwb_result),
    .sel_c_o           (fwd2_sel_c),
    .data_c_o          (fwd2_data_c)
  );

  // The select encoding has no fourth value
  a_fwd_sel_legal: assert property (@(posedge clk) disable iff (rst)
    (fwd1_sel_c inside {FWD_RF, FWD_EXMEM, FWD_MEMWB}) &&
    (fwd2_sel_c inside {FWD_RF, FWD_EXMEM, FWD_MEMWB}));

  assign bus.alu_a         = fwd1_data_c;
  assign bus.alu_b         = ctrl_q.alu_src ? data_q.imm : fwd2_data_c;
  assign bus.store_data    = fwd2_data_c;
  assign bus.alu_op        = ctrl_q.alu_op;
  assign bus.ex_rd         = data_q.rd;
  assign bus.ex_valid      = ctrl_q.valid;
  assign bus.ex_reg_write  = ctrl_q.reg_write;
  assign bus.ex_mem_read   = ctrl_q.mem_read;
  assign bus.ex_mem_write  = ctrl_q.mem_write;
  assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
  // A flush squashes the hazarding instruction, so it never stalls ID
  assign bus.stall_id      = !rst && ((load_use_c && !bus.flush) || bus.hold);

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus queues expected outputs, a monitor checks them.
module tb_id_ex_stage;
  import cpu_pkg::*;

  typedef struct {
    string       name;
    bit          c_ctrl;
    logic        ev;
    logic        rw;
    logic        mr;
    logic [4:0]  op;
    bit          c_dat;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic        st;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endtask

  // Monitor: outputs settle after stimulus at posedge+1; compare on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk({e.name, ".stall_id"}, 32'(bus.stall_id), 32'(e.st));
        if (e.c_ctrl) begin
          chk({e.name, ".ex_valid"},     32'(bus.ex_valid),     32'(e.ev));
          chk({e.name, ".ex_reg_write"}, 32'(bus.ex_reg_write), 32'(e.rw));
          chk({e.name, ".ex_mem_read"},  32'(bus.ex_mem_read),  32'(e.mr));
          chk({e.name, ".alu_op"},       32'(bus.alu_op),       32'(e.op));
        end
        if (e.c_dat) begin
          chk({e.name, ".alu_a"},      bus.alu_a,      e.a);
          chk({e.name, ".alu_b"},      bus.alu_b,      e.b);
          chk({e.name, ".store_data"}, bus.store_data, e.sd);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_full(input string n, input logic ev, rw, mr, input logic [4:0] op,
                          input logic [31:0] a, b, sd, input logic st);
    exp_t e;
    e.name = n; e.c_ctrl = 1'b1; e.ev = ev; e.rw = rw; e.mr = mr; e.op = op;
    e.c_dat = 1'b1; e.a = a; e.b = b; e.sd = sd; e.st = st;
    sb_q.push_back(e);
  endtask

  task automatic exp_ctrl(input string n, input logic ev, rw, mr, input logic [4:0] op,
                          input logic st);
    exp_t e;
    e.name = n; e.c_ctrl = 1'b1; e.ev = ev; e.rw = rw; e.mr = mr; e.op = op;
    e.c_dat = 1'b0; e.a = '0; e.b = '0; e.sd = '0; e.st = st;
    sb_q.push_back(e);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, rs2, input logic u1, u2,
                        input logic [31:0] d1, d2, imm, input logic [4:0] rd, op,
                        input logic src, rw, mr, m2r);
    bus.id_valid = v;       bus.id_rs1 = rs1;        bus.id_rs2 = rs2;
    bus.id_uses_rs1 = u1;   bus.id_uses_rs2 = u2;
    bus.id_rs1_data = d1;   bus.id_rs2_data = d2;    bus.id_imm = imm;
    bus.id_rd = rd;         bus.id_alu_op = op;      bus.id_alu_src = src;
    bus.id_reg_write = rw;  bus.id_mem_read = mr;    bus.id_mem_write = 1'b0;
    bus.id_mem_to_reg = m2r;
  endtask

  task automatic set_fwd(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mrw, input logic [4:0] mrd, input logic [31:0] mres);
    bus.exmem_reg_write = erw; bus.exmem_rd = erd; bus.exmem_result = eres;
    bus.memwb_reg_write = mrw; bus.memwb_rd = mrd; bus.memwb_result = mres;
  endtask

  // Named ID instructions reused across the sequence
  task automatic id_a(); set_id(1, 1, 2, 1, 1, 5, 7, 0, 6, ALUOP_ADD, 0, 1, 0, 0); endtask
  task automatic id_lw(); set_id(1, 1, 0, 1, 0, 5, 0, 8, 4, ALUOP_ADD, 1, 1, 1, 1); endtask
  task automatic id_use4(); set_id(1, 1, 4, 1, 1, 5, 32'hDEAD, 0, 9, ALUOP_ADD, 0, 1, 0, 0); endtask
  task automatic id_i(); set_id(1, 6, 7, 1, 1, 32'h99, 32'h77, 0, 8, ALUOP_ADD, 0, 1, 0, 0); endtask

  initial begin
    rst = 1'b1; bus.flush = 1'b0; bus.hold = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);
    id_a();
    cyc(); exp_full("reset1", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); bus.hold = 1'b1; exp_full("reset2_hold", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); rst = 1'b0; bus.hold = 1'b0; id_a(); exp_ctrl("post_reset", 0, 0, 0, 0, 0);
    cyc(); set_id(1, 1, 2, 1, 1, 5, 7, 32'hFFFF_FFFD, 6, ALUOP_ADD, 1, 1, 0, 0);
           exp_full("plain_reg", 1, 1, 0, 1, 5, 7, 7, 0);
    cyc(); set_id(1, 3, 0, 1, 1, 11, 22, 0, 7, ALUOP_SUB, 0, 1, 0, 0);
           exp_full("plain_imm", 1, 1, 0, 1, 5, 32'hFFFF_FFFD, 7, 0);
    cyc(); set_fwd(1, 3, 100, 1, 3, 200);
           exp_full("fwd_exmem", 1, 1, 0, 2, 100, 22, 22, 0);
    cyc(); set_fwd(0, 3, 100, 1, 3, 200);
           set_id(1, 0, 0, 1, 1, 33, 44, 0, 8, ALUOP_ADD, 0, 1, 0, 0);
           exp_full("fwd_memwb", 1, 1, 0, 2, 200, 22, 22, 0);
    cyc(); set_fwd(1, 0, 100, 1, 0, 200); id_lw();
           exp_full("fwd_x0", 1, 1, 0, 1, 33, 44, 44, 0);
    cyc(); set_fwd(0, 0, 0, 0, 0, 0); id_use4();
           exp_full("lw_in_ex", 1, 1, 1, 1, 5, 8, 0, 1);
    cyc(); exp_ctrl("lu_bubble", 0, 0, 0, 0, 0);
    cyc(); set_fwd(0, 0, 0, 1, 4, 32'h55); id_lw();
           exp_full("lu_capture", 1, 1, 0, 1, 5, 32'h55, 32'h55, 0);
    cyc(); set_fwd(0, 0, 0, 0, 0, 0); id_use4(); bus.flush = 1'b1;
           exp_ctrl("flush_lu", 1, 1, 1, 1, 0);
    cyc(); bus.flush = 1'b0;
           set_id(1, 2, 3, 1, 1, 32'h10, 32'h20, 0, 5, ALUOP_SUB, 0, 1, 0, 0);
           exp_ctrl("flush_bubble", 0, 0, 0, 0, 0);
    cyc(); bus.hold = 1'b1; id_i();
           exp_full("hold1", 1, 1, 0, 2, 32'h10, 32'h20, 32'h20, 1);
    cyc(); set_id(1, 9, 10, 1, 1, 32'hAA, 32'hBB, 0, 10, ALUOP_SUB, 1, 0, 1, 0);
           exp_full("hold2", 1, 1, 0, 2, 32'h10, 32'h20, 32'h20, 1);
    cyc(); id_i();
           exp_full("hold3", 1, 1, 0, 2, 32'h10, 32'h20, 32'h20, 1);
    cyc(); bus.hold = 1'b0;
           exp_full("hold_release", 1, 1, 0, 2, 32'h10, 32'h20, 32'h20, 0);
    cyc(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, ALUOP_ADD, 0, 1, 1, 0);
           exp_full("after_hold", 1, 1, 0, 1, 32'h99, 32'h77, 32'h77, 0);
    cyc(); id_a(); bus.flush = 1'b1; bus.hold = 1'b1;
           exp_ctrl("invalid_capture", 0, 0, 0, 0, 1);
    cyc(); bus.flush = 1'b0; bus.hold = 1'b0;
           set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, ALUOP_NOP, 0, 0, 0, 0);
           exp_ctrl("flush_over_hold", 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU in the 5-stage pipeline.
- Captures decoded operands and control from ID, then presents forwarded operands A and B and ALUOp to the ALU each cycle.
- Detects load-use hazards, inserts bubbles, and supports flush and hold from the rest of the pipeline.

Parameters:
- XLEN, 32, datapath width (matches ALU A/B/C).
- RAW, 5, register-index width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  RAW  source register indices
- id_uses_rs1, id_uses_rs2  in  1  instruction reads that source
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rd  in  RAW  destination index
- id_alu_op  in  5  ALU operation code
- id_alu_src  in  1  1 = B comes from imm
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits
- flush  in  1  squash the ID instruction (branch taken)
- hold  in  1  downstream stall; freeze ID/EX
- exmem_reg_write  in  1; exmem_rd  in  RAW; exmem_result  in  XLEN  EX/MEM forward source
- memwb_reg_write  in  1; memwb_rd  in  RAW; memwb_result  in  XLEN  MEM/WB forward source
- alu_a, alu_b  out  XLEN  forwarded ALU operands (combinational from registered state)
- alu_op  out  5  registered ALUOp
- store_data  out  XLEN  forwarded rs2 value, for the memory stage
- ex_rd  out  RAW; ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered control passed to EX/MEM
- stall_id  out  1  hold PC and IF/ID this cycle

Behaviour:
- Reset:
  - All registers clear to 0: ex_valid=0, all control bits 0, alu_op=5'b00000 (NOP), rd=0, data=0.
  - stall_id=0 during reset.
- Load-use hazard (combinational):
  - Asserted when ex_valid & ex_mem_read & ex_rd!=0 & id_valid, and either (id_uses_rs1 & id_rs1==ex_rd) or (id_uses_rs2 & id_rs2==ex_rd).
- stall_id = (load_use & ~flush) | hold.
- Register update priority each rising clk:
  1. rst
  2. flush: load a bubble (valid=0, all control 0, alu_op=NOP).
  3. hold: keep all registers unchanged.
  4. load_use: load a bubble.
  5. Otherwise capture all id_* inputs. When id_valid=0, capture control as 0.
- Bubble rule: a bubble never writes registers or memory. Data fields may hold any value.
- Forwarding, computed separately for rs1 and rs2 using the registered index:
  - If exmem_reg_write & exmem_rd!=0 & exmem_rd==rs: use exmem_result.
  - Else if memwb_reg_write & memwb_rd!=0 & memwb_rd==rs: use memwb_result.
  - Else use the registered rf data.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Operand selection:
  - alu_a = fwd_rs1.
  - alu_b = ex_alu_src ? ex_imm : fwd_rs2.
  - store_data = fwd_rs2 always, independent of alu_src.
- Latency:
  - ID inputs appear on outputs 1 cycle after capture.
  - Forward muxes add 0 cycles.
- Widths: all data is XLEN. No arithmetic in this block.
- Simultaneous events:
  - flush with load_use: flush wins and stall_id=0.
  - flush with hold: the bubble is loaded.
  - hold with load_use: freeze; stall_id=1.
- Reset mid-operation discards the in-flight instruction. The first capture happens on the first cycle after rst deasserts.

Decomposition:
- Shared package cpu_pkg holds:
  - ALUOP_NOP=5'b00000, ALUOP_ADD=5'b00001, ALUOP_SUB=5'b00010.
  - Forward-select encoding: FWD_RF=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2.
  - XLEN and RAW defaults.
- One sub-module, forward_unit (combinational): takes a registered rs index plus both forward sources, returns the forward select and the data. Instantiated twice.

Test Plan:
- Reset: hold rst=1 for 2 cycles with id_valid=1 -> ex_valid=0, alu_op=0, alu_a=0, stall_id=0. Release rst -> the next clk captures ID.
- Plain capture: id_rs1_data=5, id_rs2_data=7, alu_op=ADD, alu_src=0, no forward matches -> next cycle alu_a=5, alu_b=7, alu_op=5'b00001. With alu_src=1 and imm=-3 -> alu_b=32'hFFFFFFFD and store_data=7.
- Forwarding priority: ex rs1=3, exmem_rd=3 (result 100), memwb_rd=3 (result 200) -> alu_a=100. Drop exmem_reg_write -> alu_a=200. Set rs=0 with exmem_rd=0 -> rf data is used.
- Load-use: EX holds lw x4, ID instruction uses rs2=x4 -> stall_id=1 for one cycle and the next EX is a bubble (ex_reg_write=0). The cycle after, the instruction captures and alu_b=memwb_result.
- Flush vs load_use: both asserted -> stall_id=0, bubble loaded, ex_valid=0.
- Hold: hold=1 for 3 cycles while ID changes -> all outputs frozen and stall_id=1. Release hold -> the current ID is captured.
